wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  Write-back stage fed by the MEM/WB pipeline register. Selects write-back data (memory or ALU), drives the register-file write port and handles ecall side effects.
//  Ecall side effects: halt the core, latch a0 for the board display. Owns the sticky halt state used by the top level to freeze the PC and gate the clock-enable chain.
// PARAMETERS
//  WIDTH        32   datapath width (PC, IR, data, a0, a7)
//  HALT_CODE    10   a7 value meaning "exit": ecall halts the core
//  DISP_CODE    34   a7 value meaning "print a0 (hex)": ecall latches a0 to display
// PORTS
//  clk           in   1      rising-edge clock
//  rst           in   1      reset; synchronous, active-low (sampled on clk rising edge when 0)
//  en            in   1      stage enable; 0 = stall (no write, no state change)
//  RegWrite_in   in   1      register-file write request
//  MemToReg_in   in   1      1 = write MemData_in, 0 = write ALU_Result_in
//  WriteRegNo_in in   5      destination register number
//  PC_in, IR_in  in   WIDTH  PC/instruction of the retiring op (IR==0 is a bubble)
//  MemData_in    in   WIDTH  load data
//  ALU_Result_in in   WIDTH  ALU result
//  ecall_in      in   1      retiring op is ecall
//  a0_in, a7_in  in   WIDTH  forwarded a0/a7 values for ecall
//  rf_we         out  1      register-file write enable
//  rf_waddr      out  5      register-file write address
//  rf_wdata      out  WIDTH  register-file write data
//  halted        out  1      sticky halt flag
//  disp_data     out  WIDTH  last a0 printed via DISP_CODE ecall
//  disp_valid    out  1      1-cycle pulse when disp_data updates
// BEHAVIOUR
//  - Write path is combinational, zero latency: rf_wdata = MemToReg_in ? MemData_in : ALU_Result_in; rf_waddr = WriteRegNo_in.
//  - rf_we = en & RegWrite_in & (WriteRegNo_in != 0) & ~halted & ~ecall_in.
//  - FSM (1 bit): RUN -> HALT when en & ecall_in & a7_in==HALT_CODE & state==RUN. HALT is absorbing; only rst leaves it.
//    halted asserts the cycle after the halting ecall retires.
//  - Display: when en & ecall_in & a7_in==DISP_CODE & ~halted: disp_data <= a0_in, disp_valid <= 1 for exactly one cycle; otherwise disp_valid <= 0 and disp_data holds.
//  - ecall with any other a7 value: no side effect, no register write.
//  - en=0: outputs rf_we=0, all registers hold (disp_valid is cleared next cycle).
//  - Bubbles (IR_in==0) are legal; their RegWrite_in is 0 from the upstream reset, so no write occurs.
//  - Reset values (rst==0 at edge): state=RUN, halted=0, disp_data=0, disp_valid=0, optional counters=0. Reset overrides every simultaneous event, including a halting ecall in the same cycle.
//  - Reset while HALT returns to RUN next cycle.
// CONFIGURATION
//  WB_STATS_EN defined: adds outputs retired_cnt[31:0] and ecall_cnt[31:0].
//    retired_cnt increments on en & ~halted & IR_in!=0; ecall_cnt increments on en & ~halted & ecall_in.
//    Both counters wrap modulo 2^32 and reset to 0.
//  WB_STATS_EN undefined: the ports and counters do not exist.
// STRUCTURE
//  - Shared package wb_pkg: localparams ECALL_EXIT=10 and ECALL_PRINT_HEX=34; FSM state encoding WB_RUN=1'b0, WB_HALT=1'b1.
//  - One sub-module, wb_ecall_unit: FSM plus display latch (ecall decode, halted, disp_*).
//  - Write mux and counters stay in wb_stage.
// TESTING
//  1. rst=0 for 2 cycles, then rst=1 -> halted=0, disp_data=0, disp_valid=0, rf_we=0 with idle inputs.
//  2. RegWrite=1, MemToReg=0, WriteRegNo=5, ALU=0x1234 -> rf_we=1, waddr=5, wdata=0x1234.
//     Same with MemToReg=1, MemData=0xCAFE -> wdata=0xCAFE.
//     WriteRegNo=0 -> rf_we=0.
//  3. ecall, a7=34, a0=0xDEADBEEF -> next cycle disp_data=0xDEADBEEF, disp_valid=1 for one cycle only.
//     Then en=0 for 3 cycles -> disp_data holds.
//  4. ecall, a7=10 -> halted=1 next cycle.
//     Subsequent RegWrite=1 ops -> rf_we stays 0.
//     ecall a7=34 -> disp_data unchanged.
//     Then rst=0 -> halted=0.
//  5. ecall a7=10 and rst=0 in the same cycle -> halted=0 after the edge.
//     ecall a7=10 with en=0 -> no halt.
//  6. WB_STATS_EN: 5 non-bubble ops, 2 bubbles, 1 ecall a7=1 -> retired_cnt=6, ecall_cnt=1.
//     Preload check at 0xFFFFFFFF + 1 -> 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage slice.
//   ECALL_EXIT       a7 code that halts the core on ecall
//   ECALL_PRINT_HEX  a7 code that latches a0 to the board display on ecall
//   wbState_e        halt FSM encoding (RUN / HALT)
package wb_pkg;

  localparam int unsigned WB_WIDTH        = 32;
  localparam int unsigned ECALL_EXIT      = 10;
  localparam int unsigned ECALL_PRINT_HEX = 34;

  typedef enum logic {
    WB_RUN  = 1'b0,
    WB_HALT = 1'b1
  } wbState_e;

endpackage

// File: rtl/wb_stage_if.sv
// MEM/WB pipeline register outputs plus the register-file write port.
//   master : upstream side (drives MEM/WB fields, observes rf write port)
//   slave  : write-back stage (consumes MEM/WB fields, drives rf write port)
interface wb_stage_if #(
  parameter int unsigned WIDTH = 32
);

  logic             en;
  logic             RegWrite_in;
  logic             MemToReg_in;
  logic [4:0]       WriteRegNo_in;
  logic [WIDTH-1:0] PC_in;
  logic [WIDTH-1:0] IR_in;
  logic [WIDTH-1:0] MemData_in;
  logic [WIDTH-1:0] ALU_Result_in;
  logic             ecall_in;
  logic [WIDTH-1:0] a0_in;
  logic [WIDTH-1:0] a7_in;

  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [WIDTH-1:0] rf_wdata;

  modport master (
    output en, RegWrite_in, MemToReg_in, WriteRegNo_in, PC_in, IR_in,
           MemData_in, ALU_Result_in, ecall_in, a0_in, a7_in,
    input  rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  en, RegWrite_in, MemToReg_in, WriteRegNo_in, PC_in, IR_in,
           MemData_in, ALU_Result_in, ecall_in, a0_in, a7_in,
    output rf_we, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/wb_ecall_unit.sv
// Ecall side-effect unit: sticky halt FSM and display latch.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   en                  stage enable (0 = hold all state)
//   ecallIn, a7In, a0In retiring ecall and its forwarded a7/a0
//   halted              sticky halt flag (asserts the cycle after exit ecall)
//   dispData, dispValid last printed a0 and its one-cycle update strobe
module wb_ecall_unit
  import wb_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned HALT_CODE = ECALL_EXIT,
  parameter int unsigned DISP_CODE = ECALL_PRINT_HEX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ecallIn,
  input  logic [WIDTH-1:0] a7In,
  input  logic [WIDTH-1:0] a0In,
  output logic             halted,
  output logic [WIDTH-1:0] dispData,
  output logic             dispValid
);

  wbState_e state;
  wbState_e stateNext;
  logic     haltReq;
  logic     dispFire;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= WB_RUN;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    haltReq   = en & ecallIn & (a7In == WIDTH'(HALT_CODE));
    dispFire  = en & ecallIn & (a7In == WIDTH'(DISP_CODE)) & (state == WB_RUN);
    halted    = (state == WB_HALT);
    unique case (state)
      WB_RUN:  if (haltReq) stateNext = WB_HALT;
      WB_HALT: stateNext = WB_HALT;
      default: stateNext = WB_RUN;
    endcase
  end

  // Strobe drops on any cycle without a print, including stalls.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dispData  <= '0;
      dispValid <= 1'b0;
    end else begin
      dispValid <= dispFire;
      if (dispFire) dispData <= a0In;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: selects write-back data, drives the register-file write
// port and hosts the ecall side-effect unit (halt + display).
// Ports:
//   clk, rst     clock, synchronous active-low reset
//   wb           wb_stage_if.slave: MEM/WB fields in, rf_we/rf_waddr/rf_wdata out
//   halted       sticky halt flag for PC freeze / clock-enable gating
//   disp_data    last a0 printed via display ecall
//   disp_valid   one-cycle pulse when disp_data updates
//   retired_cnt, ecall_cnt  retired-op / ecall counters (only with WB_STATS_EN)
// Build option: define WB_STATS_EN to add the statistics counters.
module wb_stage
  import wb_pkg::*;
#(
  parameter int unsigned WIDTH     = WB_WIDTH,
  parameter int unsigned HALT_CODE = ECALL_EXIT,
  parameter int unsigned DISP_CODE = ECALL_PRINT_HEX
) (
  input  logic             clk,
  input  logic             rst,
  wb_stage_if.slave        wb,
  output logic             halted,
  output logic [WIDTH-1:0] disp_data,
  output logic             disp_valid
`ifdef WB_STATS_EN
  ,
  output logic [31:0]      retired_cnt,
  output logic [31:0]      ecall_cnt
`endif
);

  wb_ecall_unit #(
    .WIDTH    (WIDTH),
    .HALT_CODE(HALT_CODE),
    .DISP_CODE(DISP_CODE)
  ) ecallUnit (
    .clk      (clk),
    .rst      (rst),
    .en       (wb.en),
    .ecallIn  (wb.ecall_in),
    .a7In     (wb.a7_in),
    .a0In     (wb.a0_in),
    .halted   (halted),
    .dispData (disp_data),
    .dispValid(disp_valid)
  );

  // Zero-latency write path; ecalls never write the register file.
  always_comb begin
    wb.rf_wdata = wb.MemToReg_in ? wb.MemData_in : wb.ALU_Result_in;
    wb.rf_waddr = wb.WriteRegNo_in;
    wb.rf_we    = wb.en & wb.RegWrite_in & (wb.WriteRegNo_in != 5'd0)
                & ~halted & ~wb.ecall_in;
  end

  logic unusedInputs;

`ifdef WB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      retired_cnt <= '0;
      ecall_cnt   <= '0;
    end else if (wb.en && !halted) begin
      if (wb.IR_in != '0) retired_cnt <= retired_cnt + 32'd1;
      if (wb.ecall_in)    ecall_cnt   <= ecall_cnt + 32'd1;
    end
  end

  assign unusedInputs = ^wb.PC_in;
`else
  assign unusedInputs = ^{wb.PC_in, wb.IR_in};
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
  import wb_pkg::*;

  localparam int unsigned W = 32;

  typedef struct {
    string      tag;
    logic [W-1:0] val;
  } expItem_t;

  logic clk;
  logic rst;
  logic          halted;
  logic [W-1:0]  dispData;
  logic          dispValid;
`ifdef WB_STATS_EN
  logic [31:0]   retiredCnt;
  logic [31:0]   ecallCnt;
`endif

  wb_stage_if #(.WIDTH(W)) bus ();

  wb_stage #(.WIDTH(W), .HALT_CODE(10), .DISP_CODE(34)) dut (
    .clk        (clk),
    .rst        (rst),
    .wb         (bus.slave),
    .halted     (halted),
    .disp_data  (dispData),
    .disp_valid (dispValid)
`ifdef WB_STATS_EN
    ,
    .retired_cnt(retiredCnt),
    .ecall_cnt  (ecallCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog");
  end

  expItem_t expQ[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic expect_val(input string tag, input logic [W-1:0] v);
    expItem_t e;
    e.tag = tag;
    e.val = v;
    expQ.push_back(e);
  endtask

  task automatic check(input logic [W-1:0] obs);
    expItem_t e;
    vectors++;
    if (expQ.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard: observed %h with no expected value queued", obs);
    end else begin
      e = expQ.pop_front();
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic idle(input logic enable);
    bus.en            = enable;
    bus.RegWrite_in   = 1'b0;
    bus.MemToReg_in   = 1'b0;
    bus.WriteRegNo_in = 5'd0;
    bus.PC_in         = '0;
    bus.IR_in         = '0;
    bus.MemData_in    = '0;
    bus.ALU_Result_in = '0;
    bus.ecall_in      = 1'b0;
    bus.a0_in         = '0;
    bus.a7_in         = '0;
  endtask

  task automatic ecallOp(input logic enable, input logic [W-1:0] a7, input logic [W-1:0] a0);
    idle(enable);
    bus.ecall_in = 1'b1;
    bus.IR_in    = 32'h0000_0073;
    bus.a7_in    = a7;
    bus.a0_in    = a0;
  endtask

  task automatic writeOp(input logic m2r, input logic [4:0] rd, input logic [W-1:0] alu, input logic [W-1:0] mem);
    idle(1'b1);
    bus.RegWrite_in   = 1'b1;
    bus.MemToReg_in   = m2r;
    bus.WriteRegNo_in = rd;
    bus.ALU_Result_in = alu;
    bus.MemData_in    = mem;
    bus.IR_in         = 32'h0000_0033;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    idle(1'b0);
    tick();
    tick();
    @(negedge clk);
    rst = 1'b1;
    idle(1'b1);
    #1;
    expect_val("reset_halted", 0);      check(W'(halted));
    expect_val("reset_disp_data", 0);   check(dispData);
    expect_val("reset_disp_valid", 0);  check(W'(dispValid));
    expect_val("reset_rf_we", 0);       check(W'(bus.rf_we));

    // ALU write
    @(negedge clk);
    writeOp(1'b0, 5'd5, 32'h1234, 32'h9999);
    #1;
    expect_val("alu_we", 1);            check(W'(bus.rf_we));
    expect_val("alu_waddr", 5);         check(W'(bus.rf_waddr));
    expect_val("alu_wdata", 32'h1234);  check(bus.rf_wdata);

    // Memory write
    @(negedge clk);
    writeOp(1'b1, 5'd5, 32'h1234, 32'hCAFE);
    #1;
    expect_val("mem_we", 1);            check(W'(bus.rf_we));
    expect_val("mem_wdata", 32'hCAFE);  check(bus.rf_wdata);

    // x0 destination
    @(negedge clk);
    writeOp(1'b0, 5'd0, 32'h55, 32'h0);
    #1;
    expect_val("x0_we", 0);             check(W'(bus.rf_we));

    // Stall suppresses write
    @(negedge clk);
    writeOp(1'b0, 5'd9, 32'h77, 32'h0);
    bus.en = 1'b0;
    #1;
    expect_val("stall_we", 0);          check(W'(bus.rf_we));

    // Display ecall, with a write request that must be ignored
    @(negedge clk);
    ecallOp(1'b1, 32'd34, 32'hDEADBEEF);
    bus.RegWrite_in   = 1'b1;
    bus.WriteRegNo_in = 5'd3;
    #1;
    expect_val("ecall_we", 0);          check(W'(bus.rf_we));
    expect_val("disp_data", 32'hDEADBEEF);
    expect_val("disp_valid_pulse", 1);
    tick();
    check(dispData);
    check(W'(dispValid));
    @(negedge clk);
    idle(1'b1);
    expect_val("disp_valid_drop", 0);
    expect_val("disp_data_hold", 32'hDEADBEEF);
    tick();
    check(W'(dispValid));
    check(dispData);

    // Stalled display ecalls have no effect
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ecallOp(1'b0, 32'd34, 32'h1111_0000 + i);
      expect_val("stall_disp_data", 32'hDEADBEEF);
      tick();
      check(dispData);
    end

    // Other ecall code: no side effect
    @(negedge clk);
    ecallOp(1'b1, 32'd1, 32'hABCD);
    expect_val("other_ecall_halted", 0);
    expect_val("other_ecall_disp", 32'hDEADBEEF);
    tick();
    check(W'(halted));
    check(dispData);

    // Halting ecall
    @(negedge clk);
    ecallOp(1'b1, 32'd10, 32'h0);
    #1;
    expect_val("halt_pre", 0);          check(W'(halted));
    expect_val("halt_set", 1);
    tick();
    check(W'(halted));

    @(negedge clk);
    writeOp(1'b0, 5'd7, 32'h42, 32'h0);
    #1;
    expect_val("halted_we", 0);         check(W'(bus.rf_we));

    @(negedge clk);
    ecallOp(1'b1, 32'd34, 32'h55);
    expect_val("halted_disp_data", 32'hDEADBEEF);
    expect_val("halted_disp_valid", 0);
    expect_val("halt_sticky", 1);
    tick();
    check(dispData);
    check(W'(dispValid));
    check(W'(halted));

    // Reset leaves HALT
    @(negedge clk);
    idle(1'b1);
    rst = 1'b0;
    expect_val("rst_clears_halt", 0);
    expect_val("rst_clears_disp", 0);
    tick();
    check(W'(halted));
    check(dispData);

    // Reset wins over a simultaneous halting ecall
    @(negedge clk);
    ecallOp(1'b1, 32'd10, 32'h0);
    rst = 1'b0;
    expect_val("rst_over_halt", 0);
    tick();
    check(W'(halted));

    // Stalled halting ecall does nothing
    @(negedge clk);
    rst = 1'b1;
    ecallOp(1'b0, 32'd10, 32'h0);
    expect_val("stall_no_halt", 0);
    tick();
    check(W'(halted));

    @(negedge clk);
    writeOp(1'b0, 5'd12, 32'h600D, 32'h0);
    #1;
    expect_val("post_we", 1);           check(W'(bus.rf_we));
    expect_val("post_wdata", 32'h600D); check(bus.rf_wdata);

`ifdef WB_STATS_EN
    @(negedge clk);
    rst = 1'b0;
    idle(1'b0);
    tick();
    @(negedge clk);
    rst = 1'b1;
    #1;
    expect_val("cnt_reset_retired", 0); check(retiredCnt);
    expect_val("cnt_reset_ecall", 0);   check(ecallCnt);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      writeOp(1'b0, 5'd1, i, 32'h0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      idle(1'b1);
      tick();
    end
    @(negedge clk);
    ecallOp(1'b1, 32'd1, 32'h0);
    tick();
    @(negedge clk);
    idle(1'b0);
    #1;
    expect_val("cnt_retired", 6);       check(retiredCnt);
    expect_val("cnt_ecall", 1);         check(ecallCnt);
`endif

    if (expQ.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: observed %0d leftover, required 0", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
